spi_periph_regfile: RTL



---
 rtl/spi_periph_pkg.sv | 26 ++
 rtl/spi_edge_sync.sv | 47 ++++
 rtl/spi_periph_regfile.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_periph_pkg.sv
// ---------------------------------------------------------------------------
// spi_periph_pkg
//   Shared types and constants for the SPI register-file peripheral.
//   - state_t    : frame decoder states
//   - CMD_W      : width of the command byte on the wire
//   - CMD_RW_BIT : position of the read/write flag inside the command byte
//   - max_int    : elaboration-time helper for sizing shared registers
// ---------------------------------------------------------------------------
package spi_periph_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      WR   = 3'd2,
      RD   = 3'd3,
      SINK = 3'd4
   } state_t;

   localparam int CMD_W      = 8;
   localparam int CMD_RW_BIT = 7;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// ---------------------------------------------------------------------------
// spi_edge_sync
//   Brings the asynchronous SPI clock and data pins into the i_iclk domain
//   and turns sclk transitions into single-cycle rise/fall events.
//   Ports:
//     i_iclk, i_rst  : internal clock, asynchronous active-high reset
//     i_sclk         : raw SPI clock pin
//     i_sdata        : raw controller-to-peripheral data pin
//     o_sclk_rise    : one-cycle pulse on a synchronised sclk rising edge
//     o_sclk_fall    : one-cycle pulse on a synchronised sclk falling edge
//     o_sdata        : synchronised data bit, aligned with the sclk samples
// ---------------------------------------------------------------------------
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_iclk,
   input  logic i_rst,
   input  logic i_sclk,
   input  logic i_sdata,
   output logic o_sclk_rise,
   output logic o_sclk_fall,
   output logic o_sdata
);

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_sclk_prev;

   // Data goes through the same depth as sclk so the bit presented with a
   // rise event was sampled on the same iclk edge as the sclk high sample.
   always_ff @(posedge i_iclk or posedge i_rst) begin
      if (i_rst) begin
         r_sclk_sync <= '0;
         r_data_sync <= '0;
         r_sclk_prev <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_sdata};
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      end
   end

   assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
   assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
   assign o_sdata     = r_data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_periph_regfile.sv
// ---------------------------------------------------------------------------
// spi_periph_regfile
//   Oversampled SPI mode-0 target without chip select. A frame starts at the
//   first sclk rise and ends after IDLE_TIMEOUT iclk cycles without an sclk
//   edge. The first byte is a command (bit 7 = read, low ADDR_W bits = start
//   address); following DATA_W-bit words are burst-written to, or read from,
//   a NUM_REGS x DATA_W register file with address auto-increment.
//
//   Optional feature macro: SPI_PERIPH_READBACK_EN
//     defined   : read commands shift register contents out on o_serial_out
//     undefined : read commands park in SINK until frame end, o_serial_out
//                 is tied low and no readback logic is built
//
//   Ports:
//     i_iclk         : internal clock (>= 4x sclk)
//     i_rst          : asynchronous active-high reset
//     i_sclk         : SPI clock, asynchronous
//     i_serial_in    : controller-to-peripheral data
//     o_serial_out   : peripheral-to-controller data
//     o_reg_q        : flattened register file, reg i at [i*DATA_W +: DATA_W]
//     o_wr_stb       : one-cycle pulse per register write
//     o_wr_addr      : address of the write flagged by o_wr_stb
//     o_frame_active : high from first sclk rise until frame timeout
// ---------------------------------------------------------------------------
module spi_periph_regfile #(
   parameter int DATA_W       = 8,
   parameter int NUM_REGS     = 16,
   parameter int ADDR_W       = 7,
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic                       i_iclk,
   input  logic                       i_rst,
   input  logic                       i_sclk,
   input  logic                       i_serial_in,
   output logic                       o_serial_out,
   output logic [NUM_REGS*DATA_W-1:0] o_reg_q,
   output logic                       o_wr_stb,
   output logic [ADDR_W-1:0]          o_wr_addr,
   output logic                       o_frame_active
);

   import spi_periph_pkg::*;

   // Shift-in history only needs the bits that precede the current one; the
   // live bit is appended combinationally when a word completes.
   localparam int SHIFT_W = max_int(CMD_W, DATA_W);
   localparam int BCNT_W  = $clog2(SHIFT_W + 1);
   localparam int TO_W    = $clog2(IDLE_TIMEOUT + 1);

   // ------------------------------------------------------------------
   // Pin synchronisation and edge detection
   // ------------------------------------------------------------------
   logic w_rise;
   logic w_fall;
   logic w_din;
   logic w_edge;

   spi_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .i_iclk      (i_iclk),
      .i_rst       (i_rst),
      .i_sclk      (i_sclk),
      .i_sdata     (i_serial_in),
      .o_sclk_rise (w_rise),
      .o_sclk_fall (w_fall),
      .o_sdata     (w_din)
   );

   assign w_edge = w_rise | w_fall;

   // ------------------------------------------------------------------
   // Frame state and datapath registers
   // ------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_next;
   logic [SHIFT_W-2:0]  r_shift;
   logic [BCNT_W-1:0]   r_bit_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [TO_W-1:0]     r_to_cnt;
   logic                r_wr_stb;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic                r_frame_active;

   logic                w_cmd_done;
   logic                w_word_done;
   logic                w_timeout;
   logic                w_wr_en;
   logic                w_addr_valid;
   logic [CMD_W-1:0]    w_cmd_byte;
   logic [DATA_W-1:0]   w_word;
   logic [ADDR_W-1:0]   w_addr_inc;

   assign w_cmd_byte   = {r_shift[CMD_W-2:0], w_din};
   assign w_word       = {r_shift[DATA_W-2:0], w_din};
   // Validity is against the populated range, so an out-of-range start
   // address stays invalid until the counter itself rolls over at 2^ADDR_W.
   assign w_addr_valid = (32'(r_addr) < NUM_REGS);
   assign w_addr_inc   = (32'(r_addr) == NUM_REGS - 1) ? '0 : r_addr + ADDR_W'(1);
   assign w_wr_en      = w_word_done & w_addr_valid;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_iclk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and word-completion decode
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_cmd_done   = 1'b0;
      w_word_done  = 1'b0;
      w_timeout    = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_next = CMD;
            end
         end
         CMD: begin
            if (w_rise && (r_bit_cnt == BCNT_W'(CMD_W - 1))) begin
               w_cmd_done = 1'b1;
               if (w_cmd_byte[CMD_RW_BIT]) begin
`ifdef SPI_PERIPH_READBACK_EN
                  w_state_next = RD;
`else
                  w_state_next = SINK;
`endif
               end else begin
                  w_state_next = WR;
               end
            end
         end
         WR: begin
            if (w_rise && (r_bit_cnt == BCNT_W'(DATA_W - 1))) begin
               w_word_done = 1'b1;
            end
         end
         default: begin
         end
      endcase

      // An edge in the same cycle as the timeout keeps the frame alive.
      if (!w_edge && (r_state != IDLE) && (r_to_cnt == TO_W'(IDLE_TIMEOUT))) begin
         w_timeout    = 1'b1;
         w_state_next = IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Readback path
   // ------------------------------------------------------------------
   logic w_rd_last;

`ifdef SPI_PERIPH_READBACK_EN
   localparam int OCNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] r_shift_out;
   logic [OCNT_W-1:0] r_out_cnt;
   logic              r_serial_out;
   logic              w_rd_fall;

   // Compare-and-select mux: an address outside the populated range
   // matches nothing and therefore reads as zero.
   always_comb begin
      w_rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_addr == ADDR_W'(i)) begin
            w_rd_word = o_reg_q[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_rd_fall = (r_state == RD) & w_fall;
   assign w_rd_last = w_rd_fall & (r_out_cnt == OCNT_W'(DATA_W - 1));

   // r_out_cnt == 0 means the next fall starts a fresh word from r_addr.
   always_ff @(posedge i_iclk or posedge i_rst) begin
      if (i_rst) begin
         r_shift_out  <= '0;
         r_out_cnt    <= '0;
         r_serial_out <= 1'b0;
      end else if (w_timeout) begin
         r_out_cnt    <= '0;
         r_serial_out <= 1'b0;
      end else if (w_cmd_done) begin
         r_out_cnt    <= '0;
      end else if (w_rd_fall) begin
         if (r_out_cnt == '0) begin
            r_serial_out <= w_rd_word[DATA_W-1];
            r_shift_out  <= {w_rd_word[DATA_W-2:0], 1'b0};
         end else begin
            r_serial_out <= r_shift_out[DATA_W-1];
            r_shift_out  <= {r_shift_out[DATA_W-2:0], 1'b0};
         end
         if (w_rd_last) begin
            r_out_cnt <= '0;
         end else begin
            r_out_cnt <= r_out_cnt + OCNT_W'(1);
         end
      end
   end

   assign o_serial_out = r_serial_out;
`else
   assign w_rd_last    = 1'b0;
   assign o_serial_out = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Bit counting, addressing, timeout and write strobe
   // ------------------------------------------------------------------
   always_ff @(posedge i_iclk or posedge i_rst) begin
      if (i_rst) begin
         r_shift        <= '0;
         r_bit_cnt      <= '0;
         r_addr         <= '0;
         r_to_cnt       <= '0;
         r_wr_stb       <= 1'b0;
         r_wr_addr      <= '0;
         r_frame_active <= 1'b0;
      end else begin
         r_wr_stb       <= w_wr_en;
         r_frame_active <= (w_state_next != IDLE);

         if (w_edge) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != TO_W'(IDLE_TIMEOUT)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end

         if (w_rise) begin
            r_shift <= {r_shift[SHIFT_W-3:0], w_din};
         end

         // Counting stops in RD/SINK: incoming bits there carry no meaning.
         if (w_timeout) begin
            r_bit_cnt <= '0;
         end else if (w_rise && ((r_state == IDLE) || (r_state == CMD) || (r_state == WR))) begin
            if (w_cmd_done || w_word_done) begin
               r_bit_cnt <= '0;
            end else begin
               r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            end
         end

         if (w_cmd_done) begin
            r_addr <= w_cmd_byte[ADDR_W-1:0];
         end else if (w_word_done || w_rd_last) begin
            r_addr <= w_addr_inc;
         end

         if (w_wr_en) begin
            r_wr_addr <= r_addr;
         end
      end
   end

   assign o_wr_stb       = r_wr_stb;
   assign o_wr_addr      = r_wr_addr;
   assign o_frame_active = r_frame_active;

   // ------------------------------------------------------------------
   // Register file: one flop bank per register, written only when a full
   // word has arrived so a truncated frame never leaves partial data.
   // ------------------------------------------------------------------
   genvar gi;
   for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_reg;

      always_ff @(posedge i_iclk or posedge i_rst) begin
         if (i_rst) begin
            r_reg <= '0;
         end else if (w_wr_en && (r_addr == ADDR_W'(gi))) begin
            r_reg <= w_word;
         end
      end

      assign o_reg_q[gi*DATA_W +: DATA_W] = r_reg;
   end

endmodule
